sort_engine: RTL and testbench
==============================

// Module: sort_engine
// PURPOSE
//  Controller/datapath that sorts a contiguous region of the 256x16 data memory
//  in place, ascending unsigned, using bubble sort with early exit.
//  Sits directly upstream of the memory: drives readMem/writeMem/addrBus/inBus
//  and consumes outBus. Sorted result is left in memory for dump/readback.
// PARAMETERS
//  ADDR_W  8   memory address width; addresses wrap modulo 2**ADDR_W
//  DATA_W  16  memory word width; compare is unsigned on all DATA_W bits
// PORTS
//  clk       in   1         clock; all state changes on posedge
//  rst       in   1         reset, asynchronous, active-high
//  start     in   1         sampled in IDLE only; latches base_addr/count
//  base_addr in   ADDR_W    first word of region
//  count     in   ADDR_W+1  number of words, 0..256
//  readMem   out  1         memory read enable (async read, data same cycle)
//  writeMem  out  1         memory write enable (written on next posedge)
//  addrBus   out  ADDR_W    memory address
//  inBus     out  DATA_W    write data
//  outBus    in   DATA_W    read data from memory (Z while writeMem=1)
//  busy      out  1         high from cycle after start until DONE exits
//  done      out  1         one-cycle pulse at completion
//  swaps     out  16        swaps in current/last run; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async): state=IDLE; readMem, writeMem, busy, done = 0;
//   addrBus, inBus, swaps = 0. Reset mid-run aborts at once; memory may be
//   partially sorted; no write occurs after rst rises.
//  Regs: i (pair index), limit, swapped flag, reg_a, reg_b. ai=base+i,
//   bi=base+i+1, both mod 2**ADDR_W (region may wrap FF->00).
//  IDLE : start=1 -> latch base/count, swaps=0, swapped=0, i=0;
//         count<2 -> DONE, else limit=count-1 -> RD_A. start while busy ignored.
//  RD_A : readMem=1, addrBus=ai; reg_a<=outBus -> RD_B.
//  RD_B : readMem=1, addrBus=bi; reg_b<=outBus -> CMP.
//  CMP  : reg_a>reg_b -> WR_A; else -> NEXT. Equal values never swapped.
//  WR_A : writeMem=1, readMem=0, addrBus=ai, inBus=reg_b; swapped=1;
//         swaps++ (saturating) -> WR_B.
//  WR_B : writeMem=1, readMem=0, addrBus=bi, inBus=reg_a -> NEXT.
//  NEXT : reg_a<=max(reg_a,reg_b) (value now at bi; no re-read).
//         i+1<limit -> i++, RD_B.
//         else swapped && limit>1 -> limit--, i=0, swapped=0, RD_A.
//         else -> DONE.
//  DONE : done=1 one cycle, busy=0 -> IDLE.
//  readMem and writeMem never high together; both 0 in IDLE/CMP/NEXT/DONE.
//  Latency, already-sorted n words: 3n-1 cycles from start sample to done.
//  count=256 with base!=0 covers the whole memory, wrapping.
// STRUCTURE
//  Shared include ssc_defs.vh: ADDR_W/DATA_W defaults, state encodings
//   (IDLE,RD_A,RD_B,CMP,WR_A,WR_B,NEXT,DONE), SWAP_CNT_W=16.
//  One sub-module: sort_cmp_swap (combinational gt flag and max/min of
//   reg_a/reg_b); FSM and counters stay in sort_engine.
// TESTING (bench uses a 256x16 memory model: async read, sync write)
//  1 rst pulse mid-clock -> all outputs 0 immediately, busy=0, no writes.
//  2 base=0,count=4,mem{3,1,2,0} -> mem{0,1,2,3}, swaps=5, one done pulse.
//  3 base=0,count=4,mem{1,2,3,4} -> writeMem never 1, done 11 cycles after
//    start sampled, swaps=0.
//  4 count=0 and count=1 -> done on 2nd cycle, readMem/writeMem stay 0.
//  5 base=8'hFE,count=3,mem[FE]=5,mem[FF]=4,mem[00]=3 -> 3,4,5; mem[01] intact.
//  6 mem{16'hFFFF,16'h0000,16'h0000}: result {0,0,FFFF}, swaps=2; start
//    pulsed while busy ignored; rst during WR_A -> IDLE, target word unwritten.

Source files
------------

// File: rtl/sort_engine_pkg.sv
// Shared types and constants for the in-place bubble sort engine.
// State encoding, default bus widths and the saturating swap counter helper.
package sort_engine_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int SWAP_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CMP,
    WR_A,
    WR_B,
    NEXT,
    DONE
  } state_e;

  // Swap count sticks at all-ones instead of wrapping back to zero.
  function automatic logic [SWAP_CNT_W-1:0] satInc(input logic [SWAP_CNT_W-1:0] v);
    return (&v) ? v : v + SWAP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Compare/exchange element for the sort engine.
// Unsigned greater-than flag plus the max and min of the two held words.
module sort_cmp_swap
  import sort_engine_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              gt_o,
  output logic [DATA_W-1:0] max_o,
  output logic [DATA_W-1:0] min_o
);

  assign gt_o  = a_i > b_i;
  assign max_o = gt_o ? a_i : b_i;
  assign min_o = gt_o ? b_i : a_i;

endmodule

// File: rtl/sort_engine.sv
// In-place ascending bubble sort, with early exit, of a contiguous memory region.
// Drives the memory bus directly; addresses wrap around the top of memory.
module sort_engine
  import sort_engine_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       count,
  output logic                  readMem,
  output logic                  writeMem,
  output logic [ADDR_W-1:0]     addrBus,
  output logic [DATA_W-1:0]     inBus,
  input  logic [DATA_W-1:0]     outBus,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_CNT_W-1:0] swaps
);

  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] IDX_TWO = (ADDR_W+1)'(2);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W:0]       idx_q, idx_d;
  logic [ADDR_W:0]       limit_q, limit_d;
  logic                  swapped_q, swapped_d;
  logic [DATA_W-1:0]     regA_q, regA_d;
  logic [DATA_W-1:0]     regB_q, regB_d;
  logic [SWAP_CNT_W-1:0] swaps_q, swaps_d;

  logic              aGtB;
  logic [DATA_W-1:0] maxVal, minVal;
  logic [ADDR_W-1:0] addrA, addrB;
  logic              moreInPass, anotherPass, shortRun;

  assign addrA       = base_q + idx_q[ADDR_W-1:0];
  assign addrB       = addrA + ADDR_W'(1);
  assign moreInPass  = (idx_q + IDX_ONE) < limit_q;
  assign anotherPass = swapped_q && (limit_q > IDX_ONE);
  assign shortRun    = count < IDX_TWO;
  assign swaps       = swaps_q;

  sort_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
    .a_i  (regA_q),
    .b_i  (regB_q),
    .gt_o (aGtB),
    .max_o(maxVal),
    .min_o(minVal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = shortRun ? DONE : RD_A;
      RD_A:    state_d = RD_B;
      RD_B:    state_d = CMP;
      CMP:     state_d = aGtB ? WR_A : NEXT;
      WR_A:    state_d = WR_B;
      WR_B:    state_d = NEXT;
      NEXT: begin
        if (moreInPass)       state_d = RD_B;
        else if (anotherPass) state_d = RD_A;
        else                  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode straight from the state so an async reset silences them at once.
  always_comb begin
    readMem  = 1'b0;
    writeMem = 1'b0;
    addrBus  = '0;
    inBus    = '0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE: busy = 1'b0;
      RD_A: begin
        readMem = 1'b1;
        addrBus = addrA;
      end
      RD_B: begin
        readMem = 1'b1;
        addrBus = addrB;
      end
      WR_A: begin
        writeMem = 1'b1;
        addrBus  = addrA;
        inBus    = minVal;
      end
      WR_B: begin
        writeMem = 1'b1;
        addrBus  = addrB;
        inBus    = maxVal;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    base_d    = base_q;
    idx_d     = idx_q;
    limit_d   = limit_q;
    swapped_d = swapped_q;
    regA_d    = regA_q;
    regB_d    = regB_q;
    swaps_d   = swaps_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_addr;
          idx_d     = '0;
          limit_d   = shortRun ? '0 : count - IDX_ONE;
          swapped_d = 1'b0;
          swaps_d   = '0;
        end
      end
      RD_A: regA_d = outBus;
      RD_B: regB_d = outBus;
      WR_A: begin
        swapped_d = 1'b1;
        swaps_d   = satInc(swaps_q);
      end
      // The larger word now sits at the upper slot, so it carries forward without a re-read.
      NEXT: begin
        regA_d = maxVal;
        if (moreInPass) begin
          idx_d = idx_q + IDX_ONE;
        end else if (anotherPass) begin
          limit_d   = limit_q - IDX_ONE;
          idx_d     = '0;
          swapped_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      idx_q     <= '0;
      limit_q   <= '0;
      swapped_q <= 1'b0;
      regA_q    <= '0;
      regB_q    <= '0;
      swaps_q   <= '0;
    end else begin
      base_q    <= base_d;
      idx_q     <= idx_d;
      limit_q   <= limit_d;
      swapped_q <= swapped_d;
      regA_q    <= regA_d;
      regB_q    <= regB_d;
      swaps_q   <= swaps_d;
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: 256x16 memory model (async read, sync write) and a
// reference that sorts regions with a queue and counts inversions as expected swaps.
module tb_sort_engine;

  localparam int CYCLE_LIMIT = 20000;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  baseAddr;
  logic [8:0]  count;
  logic        readMem;
  logic        writeMem;
  logic [7:0]  addrBus;
  logic [15:0] inBus;
  logic [15:0] outBus;
  logic        busy;
  logic        done;
  logic [15:0] swaps;

  logic [15:0] mem    [256];
  logic [15:0] expMem [256];
  logic        tbWe;
  logic [7:0]  tbAddr;
  logic [15:0] tbData;

  int writeCount;
  int readCount;
  int overlapCount;
  int donePulses;

  int testsRun;
  int testsFailed;

  sort_engine dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(baseAddr),
    .count    (count),
    .readMem  (readMem),
    .writeMem (writeMem),
    .addrBus  (addrBus),
    .inBus    (inBus),
    .outBus   (outBus),
    .busy     (busy),
    .done     (done),
    .swaps    (swaps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data is deliberately garbage while the engine writes.
  assign outBus = writeMem ? ~mem[addrBus] : mem[addrBus];

  always @(posedge clk) begin
    if (writeMem) writeCount++;
    if (readMem) readCount++;
    if (readMem && writeMem) overlapCount++;
    if (done) donePulses++;
    if (writeMem) mem[addrBus] <= inBus;
    else if (tbWe) mem[tbAddr] <= tbData;
  end

  task automatic loadWord(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    tbWe = 1'b1;
    tbAddr = a;
    tbData = d;
    expMem[a] = d;
    @(negedge clk);
    tbWe = 1'b0;
  endtask

  task automatic modelSort(input logic [7:0] b, input int c, output int inv);
    logic [15:0] q[$];
    logic [7:0] a;
    inv = 0;
    for (int k = 0; k < c; k++) begin
      a = b + 8'(k);
      q.push_back(expMem[a]);
    end
    for (int i = 0; i < c; i++)
      for (int j = i + 1; j < c; j++)
        if (q[i] > q[j]) inv++;
    if (inv > 65535) inv = 65535;
    q.sort();
    for (int k = 0; k < c; k++) begin
      a = b + 8'(k);
      expMem[a] = q[k];
    end
  endtask

  task automatic runSort(input logic [7:0] b, input logic [8:0] c,
                         output int lat, output int wr, output int rd,
                         output int ov, output int dn);
    int w0, r0, o0, d0;
    @(negedge clk);
    w0 = writeCount; r0 = readCount; o0 = overlapCount; d0 = donePulses;
    baseAddr = b;
    count = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < CYCLE_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    testsRun++;
    if (done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL done timeout: base %0h count %0d, done=%b after %0d cycles, required 1", b, c, done, lat);
    end
    @(negedge clk);
    @(negedge clk);
    wr = writeCount - w0;
    rd = readCount - r0;
    ov = overlapCount - o0;
    dn = donePulses - d0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if ({readMem, writeMem, busy, done, addrBus, inBus, swaps} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset outputs: rd=%b wr=%b busy=%b done=%b addr=%h in=%h swaps=%h, required all 0",
               readMem, writeMem, busy, done, addrBus, inBus, swaps);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, wr, rd, ov, dn, inv, bad;
    logic [15:0] vals [4] = '{16'd3, 16'd1, 16'd2, 16'd0};
    for (int k = 0; k < 4; k++) loadWord(8'(k), vals[k]);
    modelSort(8'h00, 4, inv);
    runSort(8'h00, 9'd4, lat, wr, rd, ov, dn);
    bad = -1;
    for (int k = 0; k < 256; k++) if (bad < 0 && mem[k] !== expMem[k]) bad = k;
    testsRun++;
    if (bad >= 0) begin
      testsFailed++;
      $display("[TB] FAIL basic memory: addr %0h got %h required %h", bad, mem[bad], expMem[bad]);
    end
    testsRun++;
    if (swaps !== 16'd5) begin
      testsFailed++;
      $display("[TB] FAIL basic swaps: got %0d required 5", swaps);
    end
    testsRun++;
    if (dn !== 1) begin
      testsFailed++;
      $display("[TB] FAIL basic done pulses: got %0d required 1", dn);
    end
    testsRun++;
    if (ov !== 0) begin
      testsFailed++;
      $display("[TB] FAIL basic rd/wr overlap: got %0d cycles required 0", ov);
    end
  endtask

  task automatic test_sorted;
    int lat, wr, rd, ov, dn, inv;
    for (int k = 0; k < 4; k++) loadWord(8'(k), 16'(k + 1));
    modelSort(8'h00, 4, inv);
    runSort(8'h00, 9'd4, lat, wr, rd, ov, dn);
    testsRun++;
    if (lat !== 11) begin
      testsFailed++;
      $display("[TB] FAIL sorted latency: got %0d cycles required 11", lat);
    end
    testsRun++;
    if (wr !== 0) begin
      testsFailed++;
      $display("[TB] FAIL sorted writes: got %0d required 0", wr);
    end
    testsRun++;
    if (swaps !== 16'(inv)) begin
      testsFailed++;
      $display("[TB] FAIL sorted swaps: got %0d required %0d", swaps, inv);
    end
  endtask

  task automatic test_short;
    int lat, wr, rd, ov, dn, bad;
    for (int c = 0; c < 2; c++) begin
      runSort(8'h30, 9'(c), lat, wr, rd, ov, dn);
      testsRun++;
      if (lat !== 1) begin
        testsFailed++;
        $display("[TB] FAIL short count=%0d latency: got %0d required 1", c, lat);
      end
      testsRun++;
      if (rd !== 0 || wr !== 0) begin
        testsFailed++;
        $display("[TB] FAIL short count=%0d bus: reads %0d writes %0d required 0 0", c, rd, wr);
      end
      testsRun++;
      if (dn !== 1) begin
        testsFailed++;
        $display("[TB] FAIL short count=%0d done pulses: got %0d required 1", c, dn);
      end
    end
    bad = -1;
    for (int k = 0; k < 256; k++) if (bad < 0 && mem[k] !== expMem[k]) bad = k;
    testsRun++;
    if (bad >= 0) begin
      testsFailed++;
      $display("[TB] FAIL short memory: addr %0h got %h required %h", bad, mem[bad], expMem[bad]);
    end
  endtask

  task automatic test_wrap;
    int lat, wr, rd, ov, dn, inv;
    loadWord(8'hFE, 16'd5);
    loadWord(8'hFF, 16'd4);
    loadWord(8'h00, 16'd3);
    loadWord(8'h01, 16'h1234);
    modelSort(8'hFE, 3, inv);
    runSort(8'hFE, 9'd3, lat, wr, rd, ov, dn);
    testsRun++;
    if ({mem[8'hFE], mem[8'hFF], mem[8'h00]} !== {16'd3, 16'd4, 16'd5}) begin
      testsFailed++;
      $display("[TB] FAIL wrap result: got %h %h %h required 0003 0004 0005", mem[8'hFE], mem[8'hFF], mem[8'h00]);
    end
    testsRun++;
    if (mem[8'h01] !== 16'h1234) begin
      testsFailed++;
      $display("[TB] FAIL wrap neighbour: got %h required 1234", mem[8'h01]);
    end
    testsRun++;
    if (swaps !== 16'(inv)) begin
      testsFailed++;
      $display("[TB] FAIL wrap swaps: got %0d required %0d", swaps, inv);
    end
  endtask

  task automatic test_dup_busy;
    int lat, inv, bad, w0;
    loadWord(8'h40, 16'hFFFF);
    loadWord(8'h41, 16'h0000);
    loadWord(8'h42, 16'h0000);
    loadWord(8'h50, 16'd9);
    loadWord(8'h51, 16'd8);
    modelSort(8'h40, 3, inv);
    @(negedge clk);
    baseAddr = 8'h40; count = 9'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL dup busy mid-run: got %b required 1", busy);
    end
    baseAddr = 8'h50; count = 9'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < CYCLE_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    testsRun++;
    if (done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL dup done timeout: done=%b after %0d cycles, required 1", done, lat);
    end
    @(negedge clk);
    @(negedge clk);
    bad = -1;
    for (int k = 0; k < 256; k++) if (bad < 0 && mem[k] !== expMem[k]) bad = k;
    testsRun++;
    if (bad >= 0) begin
      testsFailed++;
      $display("[TB] FAIL dup memory: addr %0h got %h required %h", bad, mem[bad], expMem[bad]);
    end
    testsRun++;
    if (swaps !== 16'd2) begin
      testsFailed++;
      $display("[TB] FAIL dup swaps: got %0d required 2", swaps);
    end

    // Abort inside the first write of a two-word region.
    loadWord(8'h80, 16'd2);
    loadWord(8'h81, 16'd1);
    @(negedge clk);
    baseAddr = 8'h80; count = 9'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (writeMem !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    testsRun++;
    if (writeMem !== 1'b1 || addrBus !== 8'h80) begin
      testsFailed++;
      $display("[TB] FAIL abort reach write: wr=%b addr=%h required 1 80", writeMem, addrBus);
    end
    w0 = writeCount;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({mem[8'h80], mem[8'h81]} !== {16'd2, 16'd1} || writeCount !== w0) begin
      testsFailed++;
      $display("[TB] FAIL abort memory: got %h %h writes %0d required 0002 0001 writes 0",
               mem[8'h80], mem[8'h81], writeCount - w0);
    end
    testsRun++;
    if ({busy, swaps} !== 17'd0) begin
      testsFailed++;
      $display("[TB] FAIL abort state: busy=%b swaps=%0d required 0 0", busy, swaps);
    end
  endtask

  task automatic test_random;
    int lat, wr, rd, ov, dn, inv, bad, c;
    logic [7:0] b;
    for (int t = 0; t < 4; t++) begin
      b = 8'($urandom_range(0, 255));
      c = $urandom_range(2, 24);
      for (int k = 0; k < c; k++)
        loadWord(b + 8'(k), ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7)));
      modelSort(b, c, inv);
      runSort(b, 9'(c), lat, wr, rd, ov, dn);
      bad = -1;
      for (int k = 0; k < 256; k++) if (bad < 0 && mem[k] !== expMem[k]) bad = k;
      testsRun++;
      if (bad >= 0) begin
        testsFailed++;
        $display("[TB] FAIL random%0d memory: addr %0h got %h required %h", t, bad, mem[bad], expMem[bad]);
      end
      testsRun++;
      if (swaps !== 16'(inv) || dn !== 1 || ov !== 0) begin
        testsFailed++;
        $display("[TB] FAIL random%0d run: swaps %0d done %0d overlap %0d required %0d 1 0", t, swaps, dn, ov, inv);
      end
    end
  endtask

  task automatic test_full;
    int lat, wr, rd, ov, dn, inv, bad;
    for (int k = 0; k < 256; k++)
      loadWord(8'h10 + 8'(k), (k == 0) ? 16'hFFFF : 16'(k));
    modelSort(8'h10, 256, inv);
    runSort(8'h10, 9'd256, lat, wr, rd, ov, dn);
    bad = -1;
    for (int k = 0; k < 256; k++) if (bad < 0 && mem[k] !== expMem[k]) bad = k;
    testsRun++;
    if (bad >= 0) begin
      testsFailed++;
      $display("[TB] FAIL full memory: addr %0h got %h required %h", bad, mem[bad], expMem[bad]);
    end
    testsRun++;
    if (swaps !== 16'(inv)) begin
      testsFailed++;
      $display("[TB] FAIL full swaps: got %0d required %0d", swaps, inv);
    end
  endtask

  task automatic test_reset_midrun;
    int w0;
    for (int k = 0; k < 16; k++) loadWord(8'h90 + 8'(k), 16'($urandom_range(0, 1000)));
    @(negedge clk);
    baseAddr = 8'h90; count = 9'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midrun busy before reset: got %b required 1", busy);
    end
    #2;
    rst = 1'b1;
    w0 = writeCount;
    #1;
    testsRun++;
    if ({readMem, writeMem, busy, done, addrBus, inBus, swaps} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL midrun reset outputs: rd=%b wr=%b busy=%b done=%b addr=%h in=%h swaps=%h, required all 0",
               readMem, writeMem, busy, done, addrBus, inBus, swaps);
    end
    repeat (3) @(negedge clk);
    testsRun++;
    if (writeCount !== w0) begin
      testsFailed++;
      $display("[TB] FAIL midrun writes under reset: got %0d required 0", writeCount - w0);
    end
    rst = 1'b0;
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    writeCount = 0;
    readCount = 0;
    overlapCount = 0;
    donePulses = 0;
    rst = 1'b1;
    start = 1'b0;
    baseAddr = '0;
    count = '0;
    tbWe = 1'b0;
    tbAddr = '0;
    tbData = '0;
    test_reset();
    for (int k = 0; k < 256; k++) loadWord(8'(k), 16'($urandom));
    test_basic();
    test_sorted();
    test_short();
    test_wrap();
    test_dup_busy();
    test_random();
    test_full();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
